// File: rtl/ahb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// ahb_sram_ctrl
// AHB-Lite slave SRAM controller for a single interconnect slave slot.
// - MEM_DEPTH 32-bit words, decoded over the low WINDOW_BITS address bits.
// - WAIT_STATES extra HREADYOUT-low cycles per OKAY transfer.
// - Byte/halfword/word writes with little-endian lane strobes.
// - Read-after-write forwarding when a write commits on the edge that a read
//   of the same word is accepted.
// - Two-cycle ERROR response for out-of-window, illegal-size or misaligned
//   accesses; errored transfers never touch the RAM.
//
// Ports:
//   HCLK       clock, rising edge
//   HRESETN    synchronous active-low reset
//   HSEL       slave select
//   HADDR      byte address (low WINDOW_BITS bits decoded)
//   HTRANS     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     1 = write
//   HSIZE      0 byte, 1 halfword, 2 word, others illegal
//   HBURST     unused; every beat is an independent transfer
//   HWDATA     write data (data phase)
//   HREADYIN   bus HREADY
//   HRDATA     read data (non-zero only in a read data phase)
//   HREADYOUT  slave ready
//   HRESP      00 OKAY, 01 ERROR
// -----------------------------------------------------------------------------
module ahb_sram_ctrl #(
    parameter int unsigned MEM_DEPTH   = 8192,
    parameter int unsigned WINDOW_BITS = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    // One past the last valid byte offset, sized to compare against the window.
    localparam logic [WINDOW_BITS:0] WINDOW_LIMIT = (WINDOW_BITS + 1)'(MEM_DEPTH * 4);
    localparam logic [2:0] WAIT_CNT_INIT = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      wait_cnt_q, wait_cnt_d;
    logic            wr_pend_q, wr_pend_d;
    logic            rd_pend_q, rd_pend_d;
    logic [AW-1:0]   xfer_idx_q, xfer_idx_d;
    logic [3:0]      wr_strb_q, wr_strb_d;
    logic [3:0]      fwd_strb_q, fwd_strb_d;
    logic [31:0]     fwd_data_q, fwd_data_d;

    logic [31:0]     mem [MEM_DEPTH];
    logic [31:0]     ram_rdata;

    logic [WINDOW_BITS-1:0] offset;
    logic [AW-1:0]   acc_idx;
    logic [3:0]      acc_strb;
    logic            acc_err;
    logic            hready_int;
    logic            accept;
    logic            wr_commit;
    logic            rd_en;

    // HBURST, HTRANS[0] and the undecoded address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0], HADDR};

    assign offset  = HADDR[WINDOW_BITS-1:0];
    assign acc_idx = HADDR[AW+1:2];

    // ------------------------------------------------------------------
    // Address-phase decode: error classification and lane strobes
    // ------------------------------------------------------------------
    always_comb begin
        acc_err = 1'b0;
        if ({1'b0, offset} >= WINDOW_LIMIT) begin
            acc_err = 1'b1;
        end
        if (HSIZE > 3'd2) begin
            acc_err = 1'b1;
        end
        if ((HSIZE == 3'd1) && HADDR[0]) begin
            acc_err = 1'b1;
        end
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end

        case (HSIZE)
            3'd0:    acc_strb = 4'b0001 << HADDR[1:0];
            3'd1:    acc_strb = HADDR[1] ? 4'b1100 : 4'b0011;
            default: acc_strb = 4'b1111;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    always_comb begin
        hready_int = 1'b1;
        HRESP      = 2'b00;
        case (state_q)
            ST_WAIT: hready_int = 1'b0;
            ST_ERR1: begin
                hready_int = 1'b0;
                HRESP      = 2'b01;
            end
            ST_ERR2: HRESP = 2'b01;
            default: ;
        endcase
    end

    assign HREADYOUT = hready_int;
    assign accept    = HSEL & HTRANS[1] & HREADYIN & hready_int;

    // The edge ending a write data phase commits it; a reset on that same
    // edge drops the write instead.
    assign wr_commit = (state_q == ST_DATA) & wr_pend_q & HRESETN;
    assign rd_en     = accept & ~HWRITE & ~acc_err;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_pend_d  = wr_pend_q;
        rd_pend_d  = rd_pend_q;
        xfer_idx_d = xfer_idx_q;
        wr_strb_d  = wr_strb_q;
        fwd_strb_d = fwd_strb_q;
        fwd_data_d = fwd_data_q;

        unique case (state_q)
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q == 3'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 are all ready states.
                wr_pend_d = 1'b0;
                rd_pend_d = 1'b0;
                if (accept) begin
                    if (acc_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        wr_pend_d  = HWRITE;
                        rd_pend_d  = ~HWRITE;
                        xfer_idx_d = acc_idx;
                        wr_strb_d  = acc_strb;
                        if (WAIT_STATES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = WAIT_CNT_INIT;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // The RAM read below returns pre-write data if a write to the same
        // word commits on this edge, so remember which lanes to override.
        if (rd_en) begin
            fwd_strb_d = (wr_commit && (xfer_idx_q == acc_idx)) ? wr_strb_q : 4'b0000;
            fwd_data_d = HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            xfer_idx_q <= '0;
            wr_strb_q  <= '0;
            fwd_strb_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            xfer_idx_q <= xfer_idx_d;
            wr_strb_q  <= wr_strb_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM: byte-lane write, registered read at the accept edge
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (wr_strb_q[l]) begin
                    mem[xfer_idx_q][8*l +: 8] <= HWDATA[8*l +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_rdata <= mem[acc_idx];
        end
    end

    always_comb begin
        HRDATA = '0;
        if ((state_q == ST_DATA) && rd_pend_q) begin
            for (int unsigned l = 0; l < 4; l++) begin
                HRDATA[8*l +: 8] = fwd_strb_q[l] ? fwd_data_q[8*l +: 8] : ram_rdata[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ahb_sram_ctrl
// Two controller instances (zero and three wait states, 256 words each) are
// driven by independent pipelined AHB masters. Each master pushes the expected
// response of every transfer into a queue when it presents the address phase;
// a per-instance monitor pops and compares at the end of each data phase.
// Expected data comes from a byte-array model of the memory.
// -----------------------------------------------------------------------------
module tb_ahb_sram_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WBITS = 16;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int unsigned lows;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input int ch, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s ch%0d @%0t: got 0x%08h, expected 0x%08h", name, ch, $time, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int unsigned WS = (g == 0) ? 0 : 3;

        logic        rst_n;
        logic        hsel;
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [31:0] hwdata;
        logic        hreadyin;
        logic [31:0] hrdata;
        logic        hreadyout;
        logic [1:0]  hresp;
        bit          fin;

        assign hreadyin = hreadyout;

        ahb_sram_ctrl #(
            .MEM_DEPTH  (DEPTH),
            .WINDOW_BITS(WBITS),
            .WAIT_STATES(WS)
        ) dut (
            .HCLK     (clk),
            .HRESETN  (rst_n),
            .HSEL     (hsel),
            .HADDR    (haddr),
            .HTRANS   (htrans),
            .HWRITE   (hwrite),
            .HSIZE    (hsize),
            .HBURST   (hburst),
            .HWDATA   (hwdata),
            .HREADYIN (hreadyin),
            .HRDATA   (hrdata),
            .HREADYOUT(hreadyout),
            .HRESP    (hresp)
        );

        exp_t       expq[$];
        logic [7:0] ref_mem [DEPTH*4];

        // Sequential memory semantics: each transfer sees all earlier writes.
        function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                       input logic [2:0] size, input logic [31:0] wdata,
                                       input bit apply);
            exp_t e;
            int unsigned off, nb, base;
            off    = int'(addr[WBITS-1:0]);
            nb     = 32'd1 << size;
            e.err  = (off >= DEPTH*4) || (size > 3'd2) || ((off % nb) != 0);
            e.rd   = !wr;
            e.lows = e.err ? 1 : WS;
            e.data = '0;
            if (!e.err) begin
                if (wr && apply) begin
                    for (int unsigned i = 0; i < nb; i++) begin
                        ref_mem[off+i] = wdata[8*((off+i)%4) +: 8];
                    end
                end
                if (!wr) begin
                    base = off - (off % 4);
                    for (int unsigned i = 0; i < 4; i++) begin
                        e.data[8*i +: 8] = ref_mem[base+i];
                    end
                end
            end
            return e;
        endfunction

        // Returns #1 after the first rising edge at which HREADYOUT was high.
        task automatic wait_ready_edge(output bit ok);
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (hreadyout === 1'b1) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
            end
        endtask

        task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, input bit apply);
            bit ok;
            hsel   = 1'b1;
            htrans = 2'b10;
            haddr  = addr;
            hwrite = wr;
            hsize  = size;
            hburst = 3'($urandom);
            expq.push_back(model(wr, addr, size, wdata, apply));
            wait_ready_edge(ok);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout ch%0d @%0t: got no ready edge, expected one within 40 cycles", g, $time);
            end
            hwdata = wr ? wdata : $urandom;
        endtask

        task automatic idle(input int n);
            bit ok;
            for (int k = 0; k < n; k++) begin
                hsel   = 1'($urandom_range(0, 1));
                htrans = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
                haddr  = $urandom;
                hwrite = 1'($urandom_range(0, 1));
                hsize  = 3'($urandom);
                wait_ready_edge(ok);
                if (!ok) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL idle_timeout ch%0d @%0t: got no ready edge, expected one within 40 cycles", g, $time);
                end
                hwdata = $urandom;
            end
        endtask

        // Reset lands on the edge right after the write is accepted.
        task automatic reset_during_write(input logic [31:0] addr, input logic [31:0] wdata);
            issue(1'b1, addr, 3'd2, wdata, 1'b0);
            hsel   = 1'b0;
            htrans = 2'b00;
            rst_n  = 1'b0;
            @(posedge clk);
            #1;
            rst_n  = 1'b1;
            hwdata = $urandom;
        endtask

        initial begin : driver
            logic [31:0] a;
            logic [2:0]  sz;
            int unsigned w, lane, kind;
            fin    = 1'b0;
            rst_n  = 1'b0;
            hsel   = 1'b0;
            htrans = 2'b00;
            haddr  = '0;
            hwrite = 1'b0;
            hsize  = 3'd0;
            hburst = 3'd0;
            hwdata = '0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;

            for (int unsigned i = 0; i < DEPTH; i++) begin
                issue(1'b1, 32'(i*4), 3'd2, $urandom, 1'b1);
            end
            idle(2);

            // Back-to-back write then read of the same word.
            issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b1);
            issue(1'b0, 32'h10, 3'd2, $urandom, 1'b1);
            idle(2);

            // Byte and halfword merges; unselected lanes carry garbage.
            issue(1'b1, 32'h20, 3'd0, {24'($urandom), 8'h11}, 1'b1);
            issue(1'b1, 32'h21, 3'd0, {16'($urandom), 8'h22, 8'($urandom)}, 1'b1);
            issue(1'b1, 32'h22, 3'd1, {16'h4433, 16'($urandom)}, 1'b1);
            issue(1'b0, 32'h20, 3'd2, $urandom, 1'b1);
            idle(1);

            // Isolated read and write.
            issue(1'b0, 32'h0, 3'd2, $urandom, 1'b1);
            idle(1);
            issue(1'b1, 32'h4, 3'd2, $urandom, 1'b1);
            idle(1);

            // First address past the window, then the last valid word.
            issue(1'b0, 32'h400, 3'd2, $urandom, 1'b1);
            issue(1'b0, 32'h3FC, 3'd2, $urandom, 1'b1);
            idle(1);

            // Misaligned word write must not disturb word 0.
            issue(1'b1, 32'h2, 3'd2, 32'hCAFEF00D, 1'b1);
            issue(1'b0, 32'h0, 3'd2, $urandom, 1'b1);
            idle(1);

            reset_during_write(32'h40, 32'h5A5A1234);
            issue(1'b0, 32'h40, 3'd2, $urandom, 1'b1);
            idle(1);

            repeat (250) begin
                w  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1);
                sz = 3'($urandom_range(0, 2));
                case (sz)
                    3'd0:    lane = $urandom_range(0, 3);
                    3'd1:    lane = 2 * $urandom_range(0, 1);
                    default: lane = 0;
                endcase
                a    = {16'($urandom), 16'(w*4 + lane)};
                kind = $urandom_range(0, 11);
                if (kind == 0) begin
                    a[15:0] = 16'($urandom_range(DEPTH*4, 32'hFFFF));
                end else if (kind == 1) begin
                    sz = 3'($urandom_range(3, 7));
                end else if (kind == 2) begin
                    sz   = 3'($urandom_range(1, 2));
                    a[0] = 1'b1;
                end
                issue(1'($urandom_range(0, 1)), a, sz, $urandom, 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    idle(int'($urandom_range(1, 2)));
                end
            end
            idle(3);
            check("scoreboard_drained", g, 32'(expq.size()), 32'd0);
            fin = 1'b1;
        end

        initial begin : monitor
            bit          dp_active;
            bit          post_rst;
            int unsigned lows;
            exp_t        e;
            dp_active = 1'b0;
            post_rst  = 1'b0;
            lows      = 0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    dp_active = 1'b0;
                    post_rst  = 1'b1;
                    expq.delete();
                    continue;
                end
                if (post_rst) begin
                    check("reset_hreadyout", g, 32'(hreadyout), 32'd1);
                    check("reset_hresp", g, 32'(hresp), 32'd0);
                    check("reset_hrdata", g, hrdata, 32'd0);
                    post_rst = 1'b0;
                end
                if (dp_active) begin
                    if (hreadyout === 1'b1) begin
                        if (expq.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL scoreboard_underflow ch%0d @%0t: got a data phase end, expected no transfer", g, $time);
                        end else begin
                            e = expq.pop_front();
                            check("stall_cycles", g, 32'(lows), 32'(e.lows));
                            check("hresp_end", g, 32'(hresp), e.err ? 32'd1 : 32'd0);
                            if (e.rd && !e.err) begin
                                check("read_data", g, hrdata, e.data);
                            end else begin
                                check("hrdata_zero", g, hrdata, 32'd0);
                            end
                        end
                        dp_active = 1'b0;
                    end else begin
                        lows++;
                        if (expq.size() > 0) begin
                            check("hresp_stall", g, 32'(hresp), expq[0].err ? 32'd1 : 32'd0);
                        end
                        check("hrdata_stall", g, hrdata, 32'd0);
                    end
                end else begin
                    check("idle_hreadyout", g, 32'(hreadyout), 32'd1);
                    check("idle_hresp", g, 32'(hresp), 32'd0);
                end
                if (hreadyout === 1'b1 && hsel === 1'b1 && htrans[1] === 1'b1) begin
                    dp_active = 1'b1;
                    lows      = 0;
                end
            end
        end
    end

    initial begin : supervisor
        int unsigned cyc;
        cyc = 0;
        while (!(ch[0].fin && ch[1].fin) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(ch[0].fin && ch[1].fin)) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout @%0t: got unfinished drivers, expected completion within 20000 cycles", $time);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
